// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg : load/store codes, LSU state encoding and the alignment check
// Rev 1.0
// ============================================================================
package lsu_pkg;

  localparam logic [3:0] LOAD_LW  = 4'b0000;
  localparam logic [3:0] LOAD_LB  = 4'b0001;
  localparam logic [3:0] LOAD_LBU = 4'b0010;
  localparam logic [3:0] LOAD_LH  = 4'b0011;
  localparam logic [3:0] LOAD_LHU = 4'b0100;

  localparam logic [1:0] STORE_SW = 2'b00;
  localparam logic [1:0] STORE_SB = 2'b01;
  localparam logic [1:0] STORE_SH = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } lsu_state_e;

  // Unknown load/store codes fall back to word width, so they use the word rule.
  function automatic logic is_misaligned(input logic       we,
                                         input logic [3:0] load_sel,
                                         input logic [1:0] store_sel,
                                         input logic [1:0] off);
    logic byte_acc;
    logic half_acc;
    if (we) begin
      byte_acc = (store_sel == STORE_SB);
      half_acc = (store_sel == STORE_SH);
    end else begin
      byte_acc = (load_sel == LOAD_LB) || (load_sel == LOAD_LBU);
      half_acc = (load_sel == LOAD_LH) || (load_sel == LOAD_LHU);
    end
    if (byte_acc)      return 1'b0;
    else if (half_acc) return off[0];
    else               return (off != 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_port_if.sv
`default_nettype none
// ============================================================================
// lsu_mem_port_if : request/ready data-memory port between LSU and memory
// Rev 1.0
// ============================================================================
interface lsu_mem_port_if #(
  parameter int AW = 32
) ();

  logic          m_req;
  logic          m_we;
  logic [3:0]    m_be;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;
  logic          m_ready;

  modport master (
    output m_req, m_we, m_be, m_addr, m_wdata,
    input  m_rdata, m_ready
  );

  modport slave (
    input  m_req, m_we, m_be, m_addr, m_wdata,
    output m_rdata, m_ready
  );

endinterface
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// ============================================================================
// lsu_lane : byte-lane extraction/extension for loads, lane insertion for stores
// Rev 1.0
// ============================================================================
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  ld_off,
  input  logic [3:0]  ld_sel,
  output logic [31:0] ld_data,

  input  logic [31:0] st_data,
  input  logic [1:0]  st_off,
  input  logic [1:0]  st_sel,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_be
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = ld_word[{ld_off, 3'b000} +: 8];
    ld_half = ld_word[{ld_off[1], 4'b0000} +: 16];
    case (ld_sel)
      LOAD_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      LOAD_LBU: ld_data = {24'h000000, ld_byte};
      LOAD_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      LOAD_LHU: ld_data = {16'h0000, ld_half};
      LOAD_LW:  ld_data = ld_word;
      default:  ld_data = ld_word;
    endcase
  end

  // Sub-word stores replicate across lanes; the byte enables pick the real lane.
  always_comb begin
    case (st_sel)
      STORE_SB: begin
        st_wdata = {4{st_data[7:0]}};
        st_be    = 4'b0001 << st_off;
      end
      STORE_SH: begin
        st_wdata = {2{st_data[15:0]}};
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
      end
      STORE_SW: begin
        st_wdata = st_data;
        st_be    = 4'b1111;
      end
      default: begin
        st_wdata = st_data;
        st_be    = 4'b1111;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_port.sv
`default_nettype none
// ============================================================================
// lsu_mem_port : multi-cycle load/store unit driving a variable-latency memory
// Rev 1.0
// ============================================================================
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [3:0]    load_sel,
  input  logic [1:0]    store_sel,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          done,
  output logic          stall,
  output logic          addr_err,
  output logic          bus_err,
  lsu_mem_port_if.master mem
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_e    state_q,    state_d;
  logic [7:0]    cnt_q,      cnt_d;
  logic [3:0]    sel_q,      sel_d;
  logic [1:0]    off_q,      off_d;
  logic          we_q,       we_d;
  logic [31:0]   rdata_q,    rdata_d;
  logic          done_q,     done_d;
  logic          addr_err_q, addr_err_d;
  logic          bus_err_q,  bus_err_d;
  logic          m_req_q,    m_req_d;
  logic          m_we_q,     m_we_d;
  logic [3:0]    m_be_q,     m_be_d;
  logic [AW-1:0] m_addr_q,   m_addr_d;
  logic [31:0]   m_wdata_q,  m_wdata_d;

  logic          access;
  logic          misaligned;
  logic [31:0]   ld_data;
  logic [31:0]   st_wdata;
  logic [3:0]    st_be;

  // Load side works on the captured offset/type; store side on live inputs at capture.
  lsu_lane u_lane (
    .ld_word  (mem.m_rdata),
    .ld_off   (off_q),
    .ld_sel   (sel_q),
    .ld_data  (ld_data),
    .st_data  (wdata),
    .st_off   (addr[1:0]),
    .st_sel   (store_sel),
    .st_wdata (st_wdata),
    .st_be    (st_be)
  );

  assign access     = mem_read | mem_write;
  assign misaligned = is_misaligned(mem_write, load_sel, store_sel, addr[1:0]);
  assign stall      = ((state_q == IDLE) & access & ~misaligned) | (state_q == WAIT);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    off_d      = off_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    addr_err_d = 1'b0;
    bus_err_d  = 1'b0;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_be_d     = m_be_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;

    case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            addr_err_d = 1'b1;
          end else begin
            state_d   = WAIT;
            cnt_d     = 8'd0;
            sel_d     = load_sel;
            off_d     = addr[1:0];
            we_d      = mem_write;
            m_req_d   = 1'b1;
            m_we_d    = mem_write;
            m_be_d    = mem_write ? st_be : 4'b1111;
            m_addr_d  = {addr[AW-1:2], 2'b00};
            m_wdata_d = mem_write ? st_wdata : 32'h0;
          end
        end
      end
      WAIT: begin
        if (mem.m_ready) begin
          state_d = DONE;
          rdata_d = we_q ? 32'h0 : ld_data;
          m_req_d = 1'b0;
          done_d  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          rdata_d   = 32'h0;
          m_req_d   = 1'b0;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      sel_q      <= 4'd0;
      off_q      <= 2'd0;
      we_q       <= 1'b0;
      rdata_q    <= 32'h0;
      done_q     <= 1'b0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_be_q     <= 4'd0;
      m_addr_q   <= '0;
      m_wdata_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      off_q      <= off_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_be_q     <= m_be_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
    end
  end

  assign rdata       = rdata_q;
  assign done        = done_q;
  assign addr_err    = addr_err_q;
  assign bus_err     = bus_err_q;
  assign mem.m_req   = m_req_q;
  assign mem.m_we    = m_we_q;
  assign mem.m_be    = m_be_q;
  assign mem.m_addr  = m_addr_q;
  assign mem.m_wdata = m_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
`default_nettype none
// ============================================================================
// tb_lsu_mem_port : directed vector table, reset sequences and random traffic
// Rev 1.0
// ============================================================================
module tb_lsu_mem_port;

  localparam int TIMEOUT = 16;
  localparam int AW      = 32;
  localparam int NEVER   = 99;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read, mem_write;
  logic [3:0]    load_sel;
  logic [1:0]    store_sel;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          done, stall, addr_err, bus_err;

  int n_pass  = 0;
  int n_total = 0;

  lsu_mem_port_if #(.AW(AW)) mif ();

  lsu_mem_port #(.TIMEOUT(TIMEOUT), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .load_sel  (load_sel),
    .store_sel (store_sel),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .done      (done),
    .stall     (stall),
    .addr_err  (addr_err),
    .bus_err   (bus_err),
    .mem       (mif)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [3:0]  ls;
    logic [1:0]  ss;
    logic [31:0] a, wd, rw;
    int          lat;
    logic        hold;
    logic [31:0] e_rdata;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic        e_mis, e_berr;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    load_sel  = 4'($urandom);
    store_sel = 2'($urandom);
    addr      = $urandom;
    wdata     = $urandom;
  endtask

  // Reference model: plain arithmetic on the architectural rules.
  function automatic logic [31:0] ref_load(input logic [3:0] ls, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (ls)
      4'd1:    return (b >= 128) ? b - 32'd256 : b;
      4'd2:    return b;
      4'd3:    return (h >= 32768) ? h - 32'd65536 : h;
      4'd4:    return h;
      default: return w;
    endcase
  endfunction

  function automatic int access_bytes(input logic wr, input logic [3:0] ls, input logic [1:0] ss);
    if (wr) return (ss == 2'd1) ? 1 : (ss == 2'd2) ? 2 : 4;
    return (ls == 4'd1 || ls == 4'd2) ? 1 : (ls == 4'd3 || ls == 4'd4) ? 2 : 4;
  endfunction

  task automatic run_txn(input vec_t v);
    int  ready;
    int  nb;
    nb = access_bytes(v.wr, v.ls, v.ss);
    next_cycle();
    mem_read = v.rd; mem_write = v.wr; load_sel = v.ls; store_sel = v.ss;
    addr = v.a; wdata = v.wd; mif.m_ready = 1'b0; mif.m_rdata = $urandom;
    #1;
    chk({v.name, "/stall_c0"}, stall, !v.e_mis);
    chk({v.name, "/req_c0"}, mif.m_req, 0);
    next_cycle();
    if (!v.hold || v.e_mis) drop_inputs();
    if (v.e_mis) begin
      #1;
      chk({v.name, "/addr_err"}, addr_err, 1);
      chk({v.name, "/mis_req"}, mif.m_req, 0);
      chk({v.name, "/mis_done"}, done, 0);
      chk({v.name, "/mis_stall"}, stall, 0);
      next_cycle();
      chk({v.name, "/addr_err_pulse"}, addr_err, 0);
      chk({v.name, "/mis_done2"}, done, 0);
      chk({v.name, "/mis_req2"}, mif.m_req, 0);
      return;
    end
    for (int w = 0; w < TIMEOUT; w++) begin
      ready = (w == v.lat) ? 1 : 0;
      mif.m_ready = ready[0];
      mif.m_rdata = ready[0] ? v.rw : $urandom;
      #1;
      chk({v.name, "/req"}, mif.m_req, 1);
      chk({v.name, "/stall"}, stall, 1);
      chk({v.name, "/done_early"}, done, 0);
      chk({v.name, "/m_addr"}, mif.m_addr, v.a & 32'hFFFF_FFFC);
      chk({v.name, "/m_we"}, mif.m_we, v.wr);
      chk({v.name, "/m_be"}, mif.m_be, v.e_be);
      if (v.wr) chk({v.name, "/m_wdata"}, mif.m_wdata, v.e_wdata);
      next_cycle();
      if (ready != 0) break;
    end
    mif.m_ready = 1'b0;
    #1;
    chk({v.name, "/done"}, done, 1);
    chk({v.name, "/bus_err"}, bus_err, v.e_berr);
    chk({v.name, "/rdata"}, rdata, v.e_rdata);
    chk({v.name, "/stall_done"}, stall, 0);
    chk({v.name, "/req_done"}, mif.m_req, 0);
    next_cycle();
    drop_inputs();
    #1;
    chk({v.name, "/done_pulse"}, done, 0);
    chk({v.name, "/bus_err_pulse"}, bus_err, 0);
    chk({v.name, "/no_retrigger"}, mif.m_req, 0);
    next_cycle();
    chk({v.name, "/no_retrigger2"}, mif.m_req, 0);
    if (nb == 0) chk("unreachable", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    //        name       rd    wr    ls     ss     addr          wdata         rword         lat    hold  e_rdata       e_be     e_wdata       mis   berr
    vecs[0]  = '{"lb",    1'b1, 1'b0, 4'd1,  2'd0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0,     1'b0, 32'hFFFF_FF80, 4'b1111, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{"lbu",   1'b1, 1'b0, 4'd2,  2'd0, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0,     1'b1, 32'h0000_0080, 4'b1111, 32'h0,        1'b0, 1'b0};
    vecs[2]  = '{"sh",    1'b0, 1'b1, 4'd0,  2'd2, 32'h0000_2002, 32'h0000_BEEF, 32'h1111_2222, 3,     1'b0, 32'h0,         4'b1100, 32'hBEEF_BEEF, 1'b0, 1'b0};
    vecs[3]  = '{"lw_mis",1'b1, 1'b0, 4'd0,  2'd0, 32'h0000_3001, 32'h0,        32'h0,         0,     1'b0, 32'h0,         4'b1111, 32'h0,        1'b1, 1'b0};
    vecs[4]  = '{"lh_to", 1'b1, 1'b0, 4'd3,  2'd0, 32'h0000_4000, 32'h0,        32'h0,         NEVER, 1'b0, 32'h0,         4'b1111, 32'h0,        1'b0, 1'b1};
    vecs[5]  = '{"sb_rw", 1'b1, 1'b1, 4'd1,  2'd1, 32'h0000_5001, 32'h0000_00AB, 32'hFFFF_FFFF, 1,     1'b1, 32'h0,         4'b0010, 32'hABAB_ABAB, 1'b0, 1'b0};
    vecs[6]  = '{"sw",    1'b0, 1'b1, 4'd0,  2'd0, 32'h0000_7000, 32'h1234_5678, 32'h0,         2,     1'b0, 32'h0,         4'b1111, 32'h1234_5678, 1'b0, 1'b0};
    vecs[7]  = '{"lw",    1'b1, 1'b0, 4'd0,  2'd0, 32'h0000_8000, 32'h0,        32'hDEAD_BEEF, 1,     1'b0, 32'hDEAD_BEEF, 4'b1111, 32'h0,        1'b0, 1'b0};
    vecs[8]  = '{"sh_mis",1'b0, 1'b1, 4'd0,  2'd2, 32'h0000_0001, 32'h0,        32'h0,         0,     1'b0, 32'h0,         4'b1111, 32'h0,        1'b1, 1'b0};
    vecs[9]  = '{"lsel_x",1'b1, 1'b0, 4'd15, 2'd0, 32'h0000_9002, 32'h0,        32'h0,         0,     1'b0, 32'h0,         4'b1111, 32'h0,        1'b1, 1'b0};
    vecs[10] = '{"sb3",   1'b0, 1'b1, 4'd0,  2'd1, 32'h0000_0103, 32'h0000_0055, 32'h0,         15,    1'b0, 32'h0,         4'b1000, 32'h5555_5555, 1'b0, 1'b0};
    vecs[11] = '{"lh_neg",1'b1, 1'b0, 4'd3,  2'd0, 32'h0000_0A02, 32'h0,        32'h8001_7FFF, 0,     1'b0, 32'hFFFF_8001, 4'b1111, 32'h0,        1'b0, 1'b0};

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; load_sel = 4'd0; store_sel = 2'd0;
    addr = '0; wdata = 32'h0; mif.m_ready = 1'b0; mif.m_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/rdata", rdata, 0);
    chk("rst/done", done, 0);
    chk("rst/stall", stall, 0);
    chk("rst/addr_err", addr_err, 0);
    chk("rst/bus_err", bus_err, 0);
    chk("rst/m_req", mif.m_req, 0);
    chk("rst/m_we", mif.m_we, 0);
    chk("rst/m_be", mif.m_be, 0);
    chk("rst/m_addr", mif.m_addr, 0);
    chk("rst/m_wdata", mif.m_wdata, 0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_txn(vecs[i]);

    // Reset while waiting on memory abandons the access with no done pulse.
    next_cycle();
    mem_read = 1'b1; load_sel = 4'd3; addr = 32'h0000_4000;
    #1;
    chk("rstmid/stall0", stall, 1);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drop_inputs();
      #1;
      chk("rstmid/req", mif.m_req, 1);
    end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1;
    chk("rstmid/req_cleared", mif.m_req, 0);
    chk("rstmid/stall", stall, 0);
    chk("rstmid/done", done, 0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk("rstmid/no_done", done, 0);
      chk("rstmid/no_req", mif.m_req, 0);
    end
    v = '{"lhu_post", 1'b1, 1'b0, 4'd4, 2'd0, 32'h0000_6002, 32'h0, 32'h9000_0000, 0, 1'b0,
          32'h0000_9000, 4'b1111, 32'h0, 1'b0, 1'b0};
    run_txn(v);

    // Random traffic against the reference model.
    for (int t = 0; t < 40; t++) begin
      int sel_pick;
      logic [3:0] be;
      logic [31:0] b, h;
      v.name = "rand";
      v.wr   = 1'($urandom);
      v.rd   = v.wr ? 1'($urandom) : 1'b1;
      sel_pick = $urandom_range(0, 6);
      v.ls   = (sel_pick > 4) ? 4'($urandom_range(5, 15)) : 4'(sel_pick);
      v.ss   = 2'($urandom);
      v.a    = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        case (access_bytes(v.wr, v.ls, v.ss))
          2:       v.a[0] = 1'b0;
          4:       v.a[1:0] = 2'b00;
          default: v.a = v.a;
        endcase
      end
      v.wd   = $urandom;
      v.rw   = $urandom;
      v.lat  = ($urandom_range(0, 7) == 0) ? NEVER : $urandom_range(0, 5);
      v.hold = 1'($urandom);
      v.e_mis  = 1'b0;
      case (access_bytes(v.wr, v.ls, v.ss))
        2:       v.e_mis = (v.a % 2) != 0;
        4:       v.e_mis = (v.a % 4) != 0;
        default: v.e_mis = 1'b0;
      endcase
      v.e_berr = (v.lat >= TIMEOUT);
      b = v.wd & 32'hFF;
      h = v.wd & 32'hFFFF;
      be = 4'b1111;
      v.e_wdata = v.wd;
      if (v.wr && v.ss == 2'd1) begin
        v.e_wdata = b * 32'h0101_0101;
        be = 4'(1 << (v.a % 4));
      end else if (v.wr && v.ss == 2'd2) begin
        v.e_wdata = h * 32'h0001_0001;
        be = ((v.a % 4) >= 2) ? 4'b1100 : 4'b0011;
      end
      v.e_be    = be;
      v.e_rdata = (v.wr || v.e_berr) ? 32'h0 : ref_load(v.ls, 2'(v.a % 4), v.rw);
      run_txn(v);
      repeat ($urandom_range(0, 2)) next_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
